// File: rtl/rob_pkg.sv
// Shared constants, entry layout and tag-width helper for the reorder buffer.
package rob_pkg;

    localparam int DEF_DEPTH   = 8;
    localparam int DEF_XLEN    = 32;
    localparam int DEF_REG_AW  = 5;
    localparam int DEF_NUM_CDB = 6;

    function automatic int tag_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic                  busy;
        logic                  done;
        logic                  wen;
        logic [DEF_REG_AW-1:0] rd;
        logic [DEF_XLEN-1:0]   data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, write-back, lookup and retire signals of the reorder buffer.
interface reorder_buffer_if
    import rob_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int XLEN    = DEF_XLEN,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int NUM_CDB = DEF_NUM_CDB,
    parameter int TAG_W   = tag_w(DEPTH)
) ();

    logic                      flush;
    logic                      alloc_valid;
    logic [REG_AW-1:0]         alloc_rd;
    logic                      alloc_wen;
    logic                      alloc_ready;
    logic [TAG_W-1:0]          alloc_tag;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*XLEN-1:0]   cdb_data;
    logic [2*TAG_W-1:0]        lk_tag;
    logic [1:0]                lk_ready;
    logic [2*XLEN-1:0]         lk_data;
    logic                      commit_wen;
    logic [REG_AW-1:0]         commit_idx;
    logic [XLEN-1:0]           commit_data;
    logic [TAG_W-1:0]          commit_tag;
    logic [TAG_W:0]            count;
    logic                      empty;

    modport master (
        output flush, alloc_valid, alloc_rd, alloc_wen, cdb_valid, cdb_tag, cdb_data, lk_tag,
        input  alloc_ready, alloc_tag, lk_ready, lk_data, commit_wen, commit_idx, commit_data,
               commit_tag, count, empty
    );

    modport slave (
        input  flush, alloc_valid, alloc_rd, alloc_wen, cdb_valid, cdb_tag, cdb_data, lk_tag,
        output alloc_ready, alloc_tag, lk_ready, lk_data, commit_wen, commit_idx, commit_data,
               commit_tag, count, empty
    );

endinterface

// File: rtl/rob_cdb_match.sv
// Priority match of one tag against all CDB channels; lowest channel index wins.
module rob_cdb_match #(
    parameter int NUM_CDB = 6,
    parameter int TAG_W   = 3,
    parameter int XLEN    = 32
) (
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
    input  logic [TAG_W-1:0]         tag,
    output logic                     hit,
    output logic [XLEN-1:0]          data
);

    // Scan from the highest channel down so the lowest matching channel is the last writer
    always_comb begin
        logic            hit_v;
        logic [XLEN-1:0] data_v;
        hit_v  = 1'b0;
        data_v = {XLEN{1'b0}};
        for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (cdb_valid[i] && (cdb_tag[i*TAG_W +: TAG_W] == tag)) begin
                hit_v  = 1'b1;
                data_v = cdb_data[i*XLEN +: XLEN];
            end else begin
                hit_v  = hit_v;
                data_v = data_v;
            end
        end
        hit  = hit_v;
        data = data_v;
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer: tag allocation, CDB capture, operand lookup with
// CDB bypass, one retire per cycle and full flush.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int XLEN    = DEF_XLEN,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int NUM_CDB = DEF_NUM_CDB,
    parameter int TAG_W   = tag_w(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    reorder_buffer_if.slave rob
);

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              wen;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } entry_t;

    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W + 1)'(DEPTH);
    localparam logic [TAG_W:0] PTR_ONE   = (TAG_W + 1)'(1);

    entry_t            entries_r [DEPTH];
    logic [TAG_W:0]    head_r;
    logic [TAG_W:0]    tail_r;
    logic              commit_wen_r;
    logic [REG_AW-1:0] commit_idx_r;
    logic [XLEN-1:0]   commit_data_r;
    logic [TAG_W-1:0]  commit_tag_r;

    logic [TAG_W:0]    count_s;
    logic [TAG_W-1:0]  head_idx_s;
    logic [TAG_W-1:0]  tail_idx_s;
    logic              alloc_ready_s;
    logic              alloc_fire_s;
    logic              retire_s;
    logic [DEPTH-1:0]  wb_hit_s;
    logic [XLEN-1:0]   wb_data_s [DEPTH];
    logic [1:0]        lk_hit_s;
    logic [XLEN-1:0]   lk_byp_s [2];
    logic [1:0]        lk_ready_s;
    logic [2*XLEN-1:0] lk_data_s;

    // The wrap bit makes full (count == DEPTH) and empty (head == tail) distinguishable
    assign count_s       = tail_r - head_r;
    assign head_idx_s    = head_r[TAG_W-1:0];
    assign tail_idx_s    = tail_r[TAG_W-1:0];
    assign alloc_ready_s = (count_s < DEPTH_CNT);
    assign alloc_fire_s  = rob.alloc_valid && alloc_ready_s;
    assign retire_s      = entries_r[head_idx_s].busy && entries_r[head_idx_s].done;

    for (genvar e = 0; e < DEPTH; e++) begin : g_wb
        rob_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN)) u_wb_match (
            .cdb_valid (rob.cdb_valid),
            .cdb_tag   (rob.cdb_tag),
            .cdb_data  (rob.cdb_data),
            .tag       (TAG_W'(e)),
            .hit       (wb_hit_s[e]),
            .data      (wb_data_s[e])
        );
    end

    for (genvar p = 0; p < 2; p++) begin : g_lk
        rob_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .XLEN(XLEN)) u_lk_match (
            .cdb_valid (rob.cdb_valid),
            .cdb_tag   (rob.cdb_tag),
            .cdb_data  (rob.cdb_data),
            .tag       (rob.lk_tag[p*TAG_W +: TAG_W]),
            .hit       (lk_hit_s[p]),
            .data      (lk_byp_s[p])
        );
    end

    // Operand lookup: completed entry first, then same-cycle CDB bypass
    always_comb begin
        logic [TAG_W-1:0] t;
        lk_ready_s = 2'b00;
        lk_data_s  = {(2*XLEN){1'b0}};
        for (int p = 0; p < 2; p++) begin
            t = rob.lk_tag[p*TAG_W +: TAG_W];
            if (entries_r[t].busy && entries_r[t].done) begin
                lk_ready_s[p]              = 1'b1;
                lk_data_s[p*XLEN +: XLEN]  = entries_r[t].data;
            end else if (lk_hit_s[p]) begin
                lk_ready_s[p]              = 1'b1;
                lk_data_s[p*XLEN +: XLEN]  = lk_byp_s[p];
            end else begin
                lk_ready_s[p]              = 1'b0;
                lk_data_s[p*XLEN +: XLEN]  = {XLEN{1'b0}};
            end
        end
    end

    // Entry array, pointers and retire registers; flush beats alloc, write-back and commit
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r        <= {(TAG_W+1){1'b0}};
            tail_r        <= {(TAG_W+1){1'b0}};
            commit_wen_r  <= 1'b0;
            commit_idx_r  <= {REG_AW{1'b0}};
            commit_data_r <= {XLEN{1'b0}};
            commit_tag_r  <= {TAG_W{1'b0}};
            for (int e = 0; e < DEPTH; e++) begin
                entries_r[e] <= {$bits(entry_t){1'b0}};
            end
        end else if (rob.flush) begin
            tail_r       <= head_r;
            commit_wen_r <= 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                entries_r[e].busy <= 1'b0;
                entries_r[e].done <= 1'b0;
            end
        end else begin
            // Results for idle or already-completed entries are dropped
            for (int e = 0; e < DEPTH; e++) begin
                if (wb_hit_s[e] && entries_r[e].busy && !entries_r[e].done) begin
                    entries_r[e].done <= 1'b1;
                    entries_r[e].data <= wb_data_s[e];
                end else begin
                    entries_r[e].done <= entries_r[e].done;
                end
            end
            if (retire_s) begin
                entries_r[head_idx_s].busy <= 1'b0;
                entries_r[head_idx_s].done <= 1'b0;
                head_r        <= head_r + PTR_ONE;
                commit_wen_r  <= entries_r[head_idx_s].wen;
                commit_idx_r  <= entries_r[head_idx_s].rd;
                commit_data_r <= entries_r[head_idx_s].data;
                commit_tag_r  <= head_idx_s;
            end else begin
                commit_wen_r <= 1'b0;
            end
            if (alloc_fire_s) begin
                entries_r[tail_idx_s].busy <= 1'b1;
                entries_r[tail_idx_s].done <= 1'b0;
                entries_r[tail_idx_s].wen  <= rob.alloc_wen;
                entries_r[tail_idx_s].rd   <= rob.alloc_rd;
                entries_r[tail_idx_s].data <= {XLEN{1'b0}};
                tail_r <= tail_r + PTR_ONE;
            end else begin
                tail_r <= tail_r;
            end
        end
    end

    assign rob.alloc_ready = alloc_ready_s;
    assign rob.alloc_tag   = tail_idx_s;
    assign rob.count       = count_s;
    assign rob.empty       = (head_r == tail_r);
    assign rob.commit_wen  = commit_wen_r;
    assign rob.commit_idx  = commit_idx_r;
    assign rob.commit_data = commit_data_r;
    assign rob.commit_tag  = commit_tag_r;
    assign rob.lk_ready    = lk_ready_s;
    assign rob.lk_data     = lk_data_s;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scenario bench for reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;

    localparam int DEPTH   = 8;
    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_CDB = 6;
    localparam int TAG_W   = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reorder_buffer_if #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_AW(REG_AW), .NUM_CDB(NUM_CDB),
                        .TAG_W(TAG_W)) rob_if ();

    reorder_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_AW(REG_AW), .NUM_CDB(NUM_CDB),
                     .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .rob (rob_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rob_if.flush       = 1'b0;
        rob_if.alloc_valid = 1'b0;
        rob_if.alloc_rd    = 5'd0;
        rob_if.alloc_wen   = 1'b0;
        rob_if.cdb_valid   = 6'd0;
        rob_if.cdb_tag     = 18'd0;
        rob_if.cdb_data    = 192'd0;
        rob_if.lk_tag      = 6'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_cdb(input int ch, input logic [2:0] tag, input logic [31:0] data);
        rob_if.cdb_valid[ch]             = 1'b1;
        rob_if.cdb_tag[ch*TAG_W +: TAG_W] = tag;
        rob_if.cdb_data[ch*XLEN +: XLEN]  = data;
    endtask

    task automatic alloc_one(input logic [4:0] rd, input logic wen);
        rob_if.alloc_valid = 1'b1;
        rob_if.alloc_rd    = rd;
        rob_if.alloc_wen   = wen;
        tick();
        rob_if.alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rob_if.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0d exp 1", rob_if.empty); end
        checks++; if (rob_if.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %0d exp 1", rob_if.alloc_ready); end
        checks++; if (rob_if.alloc_tag !== 3'd0) begin errors++; $display("FAIL reset_alloc_tag got %0d exp 0", rob_if.alloc_tag); end
        checks++; if (rob_if.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", rob_if.count); end
        checks++; if ({rob_if.commit_wen, rob_if.commit_idx, rob_if.commit_data, rob_if.commit_tag} !== 41'd0) begin
            errors++; $display("FAIL reset_commit got wen=%0d idx=%0d data=%0h tag=%0d exp all 0",
                               rob_if.commit_wen, rob_if.commit_idx, rob_if.commit_data, rob_if.commit_tag); end
        checks++; if (rob_if.lk_ready !== 2'b00) begin errors++; $display("FAIL reset_lk_ready got %b exp 00", rob_if.lk_ready); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rob_if.alloc_valid = 1'b1;
            rob_if.alloc_rd    = 5'(i + 1);
            rob_if.alloc_wen   = 1'b1;
            #1;
            checks++; if (rob_if.alloc_tag !== 3'(i)) begin errors++; $display("FAIL fill_tag got %0d exp %0d", rob_if.alloc_tag, i); end
            tick();
        end
        rob_if.alloc_valid = 1'b0;
        checks++; if (rob_if.count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", rob_if.count); end
        checks++; if (rob_if.alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0d exp 0", rob_if.alloc_ready); end
        alloc_one(5'd9, 1'b1);
        checks++; if (rob_if.count !== 4'd8) begin errors++; $display("FAIL fill_ninth_count got %0d exp 8", rob_if.count); end
        checks++; if (rob_if.empty !== 1'b0) begin errors++; $display("FAIL fill_empty got %0d exp 0", rob_if.empty); end
    endtask

    task automatic test_single_commit();
        do_reset();
        alloc_one(5'd3, 1'b1);
        set_cdb(2, 3'd0, 32'h1234);
        tick();
        idle_inputs();
        checks++; if (rob_if.commit_wen !== 1'b0) begin errors++; $display("FAIL single_early_wen got %0d exp 0", rob_if.commit_wen); end
        tick();
        checks++; if (rob_if.commit_wen !== 1'b1) begin errors++; $display("FAIL single_wen got %0d exp 1", rob_if.commit_wen); end
        checks++; if (rob_if.commit_idx !== 5'd3) begin errors++; $display("FAIL single_idx got %0d exp 3", rob_if.commit_idx); end
        checks++; if (rob_if.commit_data !== 32'h1234) begin errors++; $display("FAIL single_data got %0h exp 1234", rob_if.commit_data); end
        checks++; if (rob_if.commit_tag !== 3'd0) begin errors++; $display("FAIL single_tag got %0d exp 0", rob_if.commit_tag); end
        checks++; if (rob_if.empty !== 1'b1) begin errors++; $display("FAIL single_empty got %0d exp 1", rob_if.empty); end
        tick();
        checks++; if (rob_if.commit_wen !== 1'b0) begin errors++; $display("FAIL single_pulse got %0d exp 0", rob_if.commit_wen); end
        checks++; if (rob_if.commit_idx !== 5'd3) begin errors++; $display("FAIL single_idx_hold got %0d exp 3", rob_if.commit_idx); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) alloc_one(5'(10 + i), 1'b1);
        for (int i = 2; i >= 0; i--) begin
            set_cdb(1, 3'(i), 32'(32'h20 + i));
            tick();
            idle_inputs();
            checks++; if (rob_if.commit_wen !== 1'b0) begin errors++; $display("FAIL ooo_hold_wen tag%0d got %0d exp 0", i, rob_if.commit_wen); end
        end
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++; if (rob_if.commit_wen !== 1'b1 || rob_if.commit_tag !== 3'(j) ||
                          rob_if.commit_idx !== 5'(10 + j) || rob_if.commit_data !== 32'(32'h20 + j)) begin
                errors++; $display("FAIL ooo_commit%0d got wen=%0d tag=%0d idx=%0d data=%0h exp 1/%0d/%0d/%0h",
                                   j, rob_if.commit_wen, rob_if.commit_tag, rob_if.commit_idx, rob_if.commit_data,
                                   j, 10 + j, 32'h20 + j); end
        end
        tick();
        checks++; if (rob_if.commit_wen !== 1'b0 || rob_if.empty !== 1'b1) begin
            errors++; $display("FAIL ooo_drain got wen=%0d empty=%0d exp 0/1", rob_if.commit_wen, rob_if.empty); end
    endtask

    task automatic test_cdb_priority();
        do_reset();
        for (int i = 0; i < 6; i++) alloc_one(5'(i + 1), 1'b1);
        set_cdb(0, 3'd5, 32'hA);
        set_cdb(4, 3'd5, 32'hB);
        rob_if.lk_tag = {3'd4, 3'd5};
        #1;
        checks++; if (rob_if.lk_ready !== 2'b01) begin errors++; $display("FAIL prio_bypass_ready got %b exp 01", rob_if.lk_ready); end
        checks++; if (rob_if.lk_data[31:0] !== 32'hA) begin errors++; $display("FAIL prio_bypass_data got %0h exp a", rob_if.lk_data[31:0]); end
        checks++; if (rob_if.lk_data[63:32] !== 32'h0) begin errors++; $display("FAIL prio_miss_data got %0h exp 0", rob_if.lk_data[63:32]); end
        tick();
        rob_if.cdb_valid = 6'd0;
        #1;
        checks++; if (rob_if.lk_ready[0] !== 1'b1 || rob_if.lk_data[31:0] !== 32'hA) begin
            errors++; $display("FAIL prio_entry got ready=%0d data=%0h exp 1/a", rob_if.lk_ready[0], rob_if.lk_data[31:0]); end
        checks++; if (rob_if.commit_wen !== 1'b0) begin errors++; $display("FAIL prio_no_commit got %0d exp 0", rob_if.commit_wen); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) alloc_one(5'(i + 1), 1'b1);
        for (int j = 0; j < 3; j++) set_cdb(j, 3'(j), 32'(32'h100 + j));
        tick();
        idle_inputs();
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++; if (rob_if.commit_wen !== 1'b1 || rob_if.commit_tag !== 3'(j)) begin
                errors++; $display("FAIL wrap_commit%0d got wen=%0d tag=%0d exp 1/%0d", j, rob_if.commit_wen, rob_if.commit_tag, j); end
        end
        checks++; if (rob_if.count !== 4'd5) begin errors++; $display("FAIL wrap_count5 got %0d exp 5", rob_if.count); end
        for (int j = 0; j < 3; j++) begin
            rob_if.alloc_valid = 1'b1;
            rob_if.alloc_rd    = 5'(20 + j);
            rob_if.alloc_wen   = 1'b1;
            #1;
            checks++; if (rob_if.alloc_tag !== 3'(j)) begin errors++; $display("FAIL wrap_tag got %0d exp %0d", rob_if.alloc_tag, j); end
            tick();
        end
        rob_if.alloc_valid = 1'b0;
        checks++; if (rob_if.count !== 4'd8 || rob_if.empty !== 1'b0 || rob_if.alloc_ready !== 1'b0) begin
            errors++; $display("FAIL wrap_full got count=%0d empty=%0d ready=%0d exp 8/0/0", rob_if.count, rob_if.empty, rob_if.alloc_ready); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_one(5'd20, 1'b1);
        alloc_one(5'd21, 1'b0);
        set_cdb(3, 3'd0, 32'h50);
        set_cdb(5, 3'd1, 32'h51);
        tick();
        idle_inputs();
        tick();
        tick();
        checks++; if (rob_if.commit_wen !== 1'b0 || rob_if.commit_tag !== 3'd1 || rob_if.commit_data !== 32'h51) begin
            errors++; $display("FAIL flush_nowen_commit got wen=%0d tag=%0d data=%0h exp 0/1/51", rob_if.commit_wen, rob_if.commit_tag, rob_if.commit_data); end
        for (int i = 0; i < 4; i++) alloc_one(5'(i + 1), 1'b1);
        checks++; if (rob_if.count !== 4'd4) begin errors++; $display("FAIL flush_pre_count got %0d exp 4", rob_if.count); end
        rob_if.flush       = 1'b1;
        rob_if.alloc_valid = 1'b1;
        rob_if.alloc_rd    = 5'd30;
        rob_if.alloc_wen   = 1'b1;
        set_cdb(0, 3'd2, 32'h77);
        tick();
        idle_inputs();
        rob_if.lk_tag = {3'd3, 3'd2};
        #1;
        checks++; if (rob_if.count !== 4'd0 || rob_if.empty !== 1'b1) begin
            errors++; $display("FAIL flush_state got count=%0d empty=%0d exp 0/1", rob_if.count, rob_if.empty); end
        checks++; if (rob_if.alloc_tag !== 3'd2) begin errors++; $display("FAIL flush_tag got %0d exp 2", rob_if.alloc_tag); end
        checks++; if (rob_if.commit_wen !== 1'b0) begin errors++; $display("FAIL flush_wen got %0d exp 0", rob_if.commit_wen); end
        checks++; if (rob_if.lk_ready !== 2'b00) begin errors++; $display("FAIL flush_lk got %b exp 00", rob_if.lk_ready); end
        tick();
        checks++; if (rob_if.commit_wen !== 1'b0) begin errors++; $display("FAIL flush_wen_later got %0d exp 0", rob_if.commit_wen); end
        alloc_one(5'd31, 1'b1);
        checks++; if (rob_if.count !== 4'd1 || rob_if.alloc_tag !== 3'd3) begin
            errors++; $display("FAIL flush_realloc got count=%0d tag=%0d exp 1/3", rob_if.count, rob_if.alloc_tag); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_one(5'd7, 1'b1);
        set_cdb(1, 3'd0, 32'h99);
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (rob_if.commit_wen !== 1'b0 || rob_if.commit_data !== 32'h0) begin
            errors++; $display("FAIL rstmid_commit got wen=%0d data=%0h exp 0/0", rob_if.commit_wen, rob_if.commit_data); end
        checks++; if (rob_if.empty !== 1'b1 || rob_if.count !== 4'd0) begin
            errors++; $display("FAIL rstmid_state got empty=%0d count=%0d exp 1/0", rob_if.empty, rob_if.count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_fill();
        test_single_commit();
        test_out_of_order();
        test_cdb_priority();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
